fixed_to_float: RTL and testbench

FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

---
 rtl/fixed_to_float.sv | 89 ++++++++
 tb/tb_fixed_to_float.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Serial sign-magnitude (1.7) to IEEE-754 single-precision converter.
// Normalises one bit per cycle with a ready/valid handshake on each side.
module fixed_to_float #(
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_float,
    input  logic        out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The exponent starts as if the leading one were at bit 6 and walks down.
    localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS + 6);

    logic [1:0]  r_state;
    logic [6:0]  r_shreg;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic [31:0] r_out_float;

    logic [6:0]  w_mag;
    logic        w_mag_zero;

    assign w_mag      = in_data[6:0];
    assign w_mag_zero = (w_mag == 7'd0);

    // Handshake flags decode the state register only, so neither depends on an input.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_float = r_out_float;

    // NOTE: every register here uses non-blocking assignment so all updates
    // within an edge see the pre-edge values of the other registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_out_float <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_data[7];
                        r_shreg <= w_mag;
                        r_exp   <= EXP_INIT;
                        if (w_mag_zero) begin
                            // A zero magnitude yields +0 regardless of the sign bit.
                            r_out_float <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end

                S_NORM: begin
                    if (r_shreg[6]) begin
                        r_out_float <= {r_sign, r_exp, r_shreg[5:0], 17'b0};
                        r_state     <= S_DONE;
                    end else begin
                        r_shreg <= {r_shreg[5:0], 1'b0};
                        r_exp   <= r_exp - 8'd1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed-vector, corner-sequence and full-sweep bench for fixed_to_float.
// Expected values are hand-computed constants or an independent reference model.
module tb_fixed_to_float;

    localparam int EXP_BIAS = 127;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_float;
    logic        out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  din;
        logic [31:0] exp_float;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    fixed_to_float #(.EXP_BIAS(EXP_BIAS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_float (out_float),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Independent model: locate the leading one directly and align the remainder.
    function automatic logic [31:0] ref_conv(input logic [7:0] d);
        logic [6:0]  m;
        int          p;
        logic [31:0] sh;
        m = d[6:0];
        if (m == 7'd0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 7; i++) if (m[i]) p = i;
        sh = 32'(m) << (23 - p);
        return {d[7], 8'(EXP_BIAS + p), sh[22:0]};
    endfunction

    // Waits (bounded) for in_ready, then presents one word for exactly one edge.
    task automatic send(input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts latency after the handshake edge; 99 means out_valid never rose.
    task automatic wait_valid(output int lat);
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        out_ready = 1'b1;
        send(v.din);
        wait_valid(lat);
        check($sformatf("vec%0d_lat(%h)", idx, v.din), 32'(lat), 32'(v.exp_lat));
        check($sformatf("vec%0d_float(%h)", idx, v.din), out_float, v.exp_float);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_idle_ready", idx), {30'd0, in_ready, out_valid}, 32'b10);
        check($sformatf("vec%0d_retain", idx), out_float, v.exp_float);
    endtask

    initial begin
        int lat;
        int converted;
        logic got;
        logic done;

        vecs[0]  = '{8'h01, 32'h3F80_0000, 8};
        vecs[1]  = '{8'h7F, 32'h42FE_0000, 2};
        vecs[2]  = '{8'h85, 32'hC0A0_0000, 6};
        vecs[3]  = '{8'h00, 32'h0000_0000, 1};
        vecs[4]  = '{8'h80, 32'h0000_0000, 1};
        vecs[5]  = '{8'h40, 32'h4280_0000, 2};
        vecs[6]  = '{8'h03, 32'h4040_0000, 7};
        vecs[7]  = '{8'h81, 32'hBF80_0000, 8};
        vecs[8]  = '{8'h02, 32'h4000_0000, 7};
        vecs[9]  = '{8'hFF, 32'hC2FE_0000, 2};
        vecs[10] = '{8'h0A, 32'h4120_0000, 5};
        vecs[11] = '{8'hC0, 32'hC280_0000, 2};

        // Reset state, checked before any clock edge has been seen.
        #1 rst = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_float", out_float, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result held, input ignored, handshake completes on out_ready.
        out_ready = 1'b0;
        send(8'h40);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold_float_%0d", c), out_float, 32'h4280_0000);
            check($sformatf("bp_hold_flags_%0d", c), {30'd0, in_ready, out_valid}, 32'b01);
            in_valid = (c == 2);
            in_data  = 8'h01;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        check("bp_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_flags", {30'd0, in_ready, out_valid}, 32'b10);
        check("bp_release_retain", out_float, 32'h4280_0000);
        run_vec('{8'h03, 32'h4040_0000, 7}, 100);

        // Reset during NORM discards the conversion in progress.
        send(8'h01);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_pre_norm_flags", {30'd0, in_ready, out_valid}, 32'b00);
        rst = 1'b1;
        #1;
        check("rst_async_flags", {30'd0, in_ready, out_valid}, 32'b10);
        check("rst_async_float", out_float, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check("rst_no_valid_pulse", 32'(got), 32'd0);
        run_vec('{8'h03, 32'h4040_0000, 7}, 101);

        // Sweep of every input under random output stalls, in order.
        converted = 0;
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            got  = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                @(negedge clk);
                if (out_valid && !got) begin
                    got = 1'b1;
                    converted++;
                    check($sformatf("sweep_%02h", v), out_float, ref_conv(8'(v)));
                end else if (out_valid) begin
                    check($sformatf("sweep_stable_%02h", v), out_float, ref_conv(8'(v)));
                end
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    @(posedge clk);
                    done = 1'b1;
                end
            end
            if (!done) check($sformatf("sweep_timeout_%02h", v), 32'(done), 32'd1);
        end
        check("sweep_count", 32'(converted), 32'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
